// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: a W-bit word in on valid/ready, one bit out per serial beat.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t         state_reg, state_next;
  logic [W-1:0]   shift_reg, shift_next, shift_adv;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           data_bit;
  logic           last_data;
`ifdef PISO_PARITY_EN
  logic           parity_reg, parity_next;
`endif

  // The register always shifts toward the end that drives ser_out.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_adv = {shift_reg[W-2:0], 1'b0};
      assign data_bit  = shift_reg[W-1];
    end else begin : g_lsb
      assign shift_adv = {1'b0, shift_reg[W-1:1]};
      assign data_bit  = shift_reg[0];
    end
  endgenerate

  assign last_data = (cnt_reg == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
`ifdef PISO_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      cnt_reg    <= cnt_next;
`ifdef PISO_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    cnt_next    = cnt_reg;
`ifdef PISO_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (par_valid) begin
          shift_next  = par_data;
          cnt_next    = '0;
`ifdef PISO_PARITY_EN
          parity_next = ^par_data;
`endif
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          shift_next = shift_adv;
          cnt_next   = cnt_reg + 1'b1;
          if (last_data) begin
`ifdef PISO_PARITY_EN
            state_next = PARITY;
`else
            state_next = IDLE;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (ser_ready) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // All outputs decode registered state only; no input-to-output paths.
  assign par_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign ser_valid = (state_reg != IDLE);

`ifdef PISO_PARITY_EN
  assign ser_out  = (state_reg == PARITY) ? parity_reg : ((state_reg == SHIFT) & data_bit);
  assign ser_last = (state_reg == PARITY);
`else
  assign ser_out  = (state_reg == SHIFT) & data_bit;
  assign ser_last = (state_reg == SHIFT) & last_data;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances run in lockstep on shared stimulus.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] par_data;
  logic         par_valid;
  logic         ser_ready;

  logic m_par_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
  logic l_par_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;

  exp_t q_msb[$];
  exp_t q_lsb[$];
  logic model_busy;
  int   errors = 0;
  int   checks = 0;

  piso_serializer #(.W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .par_data(par_data), .par_valid(par_valid),
    .par_ready(m_par_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .ser_ready(ser_ready), .ser_last(m_ser_last), .busy(m_busy)
  );

  piso_serializer #(.W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .par_data(par_data), .par_valid(par_valid),
    .par_ready(l_par_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .ser_ready(ser_ready), .ser_last(l_ser_last), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.last = (i == W - 1) && !PAR;
      e.b = d[W-1-i];
      q_msb.push_back(e);
      e.b = d[i];
      q_lsb.push_back(e);
    end
    if (PAR) begin
      e.b = ^d;
      e.last = 1'b1;
      q_msb.push_back(e);
      q_lsb.push_back(e);
    end
  endtask

  // One clock: compare pre-edge outputs with the model, advance the model, take the edge.
  task automatic tick();
    exp_t e;
    logic busy_next;
    if (rst) begin
      @(posedge clk); #1;
      q_msb.delete();
      q_lsb.delete();
      model_busy = 1'b0;
      return;
    end
    busy_next = model_busy;
    check("m_valid", m_ser_valid, model_busy);
    check("l_valid", l_ser_valid, model_busy);
    check("m_busy", m_busy, model_busy);
    check("m_par_ready", m_par_ready, !model_busy);
    check("l_par_ready", l_par_ready, !model_busy);
    if (!m_ser_valid) check("m_idle_out", {m_ser_out, m_ser_last}, 2'b00);
    if (model_busy && ser_ready) begin
      if (q_msb.size() == 0 || q_lsb.size() == 0) begin
        check("q_underflow", 1, 0);
      end else begin
        e = q_msb.pop_front();
        check("m_bit", m_ser_out, e.b);
        check("m_last", m_ser_last, e.last);
        e = q_lsb.pop_front();
        check("l_bit", l_ser_out, e.b);
        check("l_last", l_ser_last, e.last);
        if (e.last) busy_next = 1'b0;
      end
    end else if (model_busy) begin
      e = q_msb[0];
      check("m_hold_bit", m_ser_out, e.b);
      check("m_hold_last", m_ser_last, e.last);
    end
    if (!model_busy && par_valid) begin
      push_word(par_data);
      busy_next = 1'b1;
    end
    model_busy = busy_next;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [W-1:0] d);
    par_data  = d;
    par_valid = 1'b1;
    tick();
    par_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; par_data = '0; par_valid = 1'b1; ser_ready = 1'b1;
    model_busy = 1'b0;
    ticks(2);
    rst = 1'b0; par_valid = 1'b0;
    check("rst_valid", m_ser_valid, 0);
    check("rst_par_ready", m_par_ready, 1);
    check("rst_busy", m_busy, 0);
    check("rst_out", {m_ser_out, m_ser_last}, 0);

    // Plain words, ser_ready held high
    send(8'hA5); ticks(W + 1 + PAR);
    send(8'h01); ticks(W + 1 + PAR);
    send(8'h07); ticks(W + 1 + PAR);

    // Backpressure while bit index 2 is presented
    send(8'hA5); ticks(2);
    ser_ready = 1'b0; ticks(3);
    ser_ready = 1'b1; ticks(W + PAR);

    // Inputs ignored while busy; second word taken on the idle cycle
    par_data = 8'hFF; par_valid = 1'b1; tick();
    par_data = 8'h00; ticks(W + PAR + 1);
    par_valid = 1'b0; ticks(W + 1 + PAR);

    // Reset mid-word
    send(8'hC3); ticks(3);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("mid_rst_valid", m_ser_valid, 0);
    check("mid_rst_last", m_ser_last, 0);
    check("mid_rst_busy", l_busy, 0);
    check("mid_rst_ready", m_par_ready, 1);
    send(8'h3C); ticks(W + 1 + PAR);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      par_data  = W'($urandom);
      par_valid = ($urandom_range(0, 2) != 0);
      ser_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    par_valid = 1'b0; ser_ready = 1'b1;
    ticks(2 * W + 4);
    check("q_msb_drained", q_msb.size(), 0);
    check("q_lsb_drained", q_lsb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter: accepts a W-bit word on a valid/ready handshake and shifts it out one bit per accepted serial beat.
- It is the sending end for the team's serial shift-chain receivers. Bits are driven onto a single-bit stream with its own valid/ready, and the word's final bit is flagged.
- Intended as the source feeding bit-serial pipelines and FSM exercises in the same tree.

Parameters:
- W, 8, word width in bits; legal range W >= 2.
- MSB_FIRST, 1, 1 = bit W-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- par_data  input  W  word to serialize; sampled only on the accept edge.
- par_valid  input  1  upstream word available.
- par_ready  output  1  block can accept a word (high only in IDLE).
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  downstream consumes the bit on this edge when ser_valid=1.
- ser_last  output  1  current bit is the last bit of the word.
- busy  output  1  a word is in flight (state != IDLE).

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE; shift register and bit counter clear to 0.
  - ser_out=0, ser_valid=0, ser_last=0, busy=0.
  - par_ready reads 1 from the first cycle after the reset edge.
  - par_valid is ignored while rst=1.
- States: IDLE and SHIFT, plus PARITY when the optional feature is compiled in.
- par_ready = (state==IDLE). It is decoded from registered state and has no combinational path from ser_ready or par_valid.
- Accept:
  - Occurs on the edge where state==IDLE and par_valid=1.
  - par_data is loaded into the shift register and the counter is set to 0; next state is SHIFT.
  - The first bit appears on ser_out with ser_valid=1 in the cycle after the accept edge (1-cycle latency).
- SHIFT:
  - ser_valid=1 throughout.
  - ser_out is the MSB of the shift register when MSB_FIRST=1, otherwise the LSB.
  - A bit advances only on an edge where ser_valid=1 and ser_ready=1: the register shifts toward the output end and the counter increments.
  - With ser_ready=0, ser_out, ser_last and the counter hold indefinitely.
- ser_last = 1 while the counter equals W-1 (and no parity bit follows).
  - When that bit is accepted, next state is IDLE.
  - ser_valid, ser_last and ser_out drop to 0 in the following cycle, and par_ready rises in that same cycle.
- Throughput: with ser_ready held at 1, one word per W+1 cycles. The single IDLE cycle between words is mandatory.
- Counter width is $clog2(W+1). It never wraps within a word.
- When ser_valid=0, ser_out is driven 0.
- par_valid/par_data are ignored while busy=1. Dropping par_valid while busy has no effect.
- Reset mid-word: the word is abandoned with no further bits and no ser_last. Outputs return to reset values on that edge.
- busy = (state != IDLE), from registered state.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - On accept, the even parity of par_data (XOR reduction) is captured.
  - After data bit W-1 is accepted, the FSM enters PARITY and presents the parity bit with ser_valid=1 and ser_last=1.
  - ser_last is 0 on data bit W-1.
  - The parity bit obeys the same ser_ready hold rule. On its acceptance, next state is IDLE.
  - Throughput is one word per W+2 cycles.
- Undefined: no PARITY state and no parity register. Behaviour is exactly as above.

Test Plan:
- Serial order, MSB first: W=8, MSB_FIRST=1, ser_ready=1, accept 8'hA5 at cycle 0.
  - Required: ser_out = 1,0,1,0,0,1,0,1 on cycles 1..8.
  - ser_last only on cycle 8; par_ready=1 and ser_valid=0 on cycle 9.
- Serial order, LSB first: MSB_FIRST=0, accept 8'h01.
  - Required: first bit 1, then seven 0s; ser_last on the 8th bit.
- Backpressure: 8'hA5, MSB first, ser_ready=0 for 3 cycles while bit index 2 (value 1) is presented.
  - Required: ser_out=1, ser_valid=1 and counter stable for all 3 cycles.
  - Remaining bits are correct and in order; ser_last is on cycle 11.
- Busy handling: par_valid held high with 8'hFF, then par_data changed to 8'h00 during SHIFT.
  - Required: 8 ones are sent; par_ready=0 throughout.
  - 8'h00 is accepted on the IDLE cycle (cycle 9) and its first bit appears on cycle 10.
- Reset mid-word: rst=1 for 1 cycle after 3 bits of 8'hC3.
  - Required: the next cycle shows ser_valid=0, ser_last=0, busy=0, par_ready=1.
  - No further bits of 8'hC3 are sent; a new word 8'h3C serializes correctly.
- PISO_PARITY_EN defined:
  - 8'hA5 → 9th bit 0 with ser_last=1, and ser_last=0 on bit 8.
  - 8'h07 → 9th bit 1.
  - par_ready returns on cycle 10.
